// File: rtl/dp_pkg.sv
// Shared definitions for the datapath scheduler and the datapath controller:
// FSM state encoding and the one-hot operand-capture strobes.
package dp_pkg;

  // FSM state encoding (3 bits; 3'd7 is the only illegal code)
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CAP_A   = 3'd1;
  localparam state_t ST_CAP_B   = 3'd2;
  localparam state_t ST_CAP_C   = 3'd3;
  localparam state_t ST_CAP_D   = 3'd4;
  localparam state_t ST_OPERATE = 3'd5;
  localparam state_t ST_RESPOND = 3'd6;

  // Operand-capture strobes seen by the datapath (bit0 = operand A)
  localparam logic [3:0] CAP_NONE = 4'b0000;
  localparam logic [3:0] CAP_A    = 4'b0001;
  localparam logic [3:0] CAP_B    = 4'b0010;
  localparam logic [3:0] CAP_C    = 4'b0100;
  localparam logic [3:0] CAP_D    = 4'b1000;

  // Capture strobe implied by a state; every non-capture state is silent
  function automatic logic [3:0] cap_strobe(input state_t s);
    case (s)
      ST_CAP_A: cap_strobe = CAP_A;
      ST_CAP_B: cap_strobe = CAP_B;
      ST_CAP_C: cap_strobe = CAP_C;
      ST_CAP_D: cap_strobe = CAP_D;
      default:  cap_strobe = CAP_NONE;
    endcase
  endfunction

  // True for every code the FSM can legally hold
  function automatic logic state_legal(input state_t s);
    state_legal = (s <= ST_RESPOND);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection. Search begins one past the last granted
// index and wraps, so the previous owner has lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic w_found;

  // Scan N_REQ positions starting at last+1; first requester seen wins
  always_comb begin
    int j;
    j        = 0;
    w_found  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(i_last) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && i_req[j]) begin
        w_found     = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/dp_scheduler.sv
// Shares one 4-operand datapath among N_REQ requesters. A round-robin
// winner is granted, its operands are strobed in over four capture cycles,
// the datapath computes for one cycle, and the result is presented until
// the consumer accepts it. Acceptance re-arbitrates with no idle bubble.
module dp_scheduler
  import dp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                     i_clock,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*W-1:0]       i_req_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [3:0]               o_capture,
  output logic                     o_op,
  output logic [W-1:0]             o_dp_in,
  input  logic [W-1:0]             i_dp_result,
  output logic                     o_valid,
  output logic [$clog2(N_REQ)-1:0] o_resp_id,
  output logic [W-1:0]             o_resp_data,
  input  logic                     i_resp_ready,
  output logic                     o_busy
);

  localparam int IW = $clog2(N_REQ);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IW-1:0]    r_gnt_idx;
  logic [IW-1:0]    r_last;
  logic             r_first;   // first cycle of RESPOND: result is live on i_dp_result
  logic [W-1:0]     r_held;    // result snapshot for the remaining RESPOND cycles

  logic [N_REQ-1:0] w_win;
  logic [IW-1:0]    w_win_idx;
  logic             w_any;
  logic             w_legal;
  logic             w_resp;
  logic [N_REQ-1:0] w_gnt;
  logic [W-1:0]     w_dp_in;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  // Transaction sequencing and grant register; arbitration happens only in
  // IDLE or on the accepting RESPOND edge, so gnt is frozen mid-transaction
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_last    <= IW'(N_REQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_win;
            r_gnt_idx <= w_win_idx;
            r_last    <= w_win_idx;
            r_state   <= ST_CAP_A;
          end
        end
        ST_CAP_A:   r_state <= ST_CAP_B;
        ST_CAP_B:   r_state <= ST_CAP_C;
        ST_CAP_C:   r_state <= ST_CAP_D;
        ST_CAP_D:   r_state <= ST_OPERATE;
        ST_OPERATE: r_state <= ST_RESPOND;
        ST_RESPOND: begin
          if (i_resp_ready) begin
            if (w_any) begin
              r_gnt     <= w_win;
              r_gnt_idx <= w_win_idx;
              r_last    <= w_win_idx;
              r_state   <= ST_CAP_A;
            end else begin
              r_gnt     <= '0;
              r_gnt_idx <= '0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gnt     <= '0;
          r_gnt_idx <= '0;
        end
      endcase
    end
  end

  // Freeze the datapath result after the first RESPOND cycle so the
  // response stays stable however long the consumer stalls
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first <= 1'b0;
      r_held  <= '0;
    end else begin
      r_first <= (r_state == ST_OPERATE);
      if (r_state == ST_RESPOND && r_first) r_held <= i_dp_result;
    end
  end

  assign w_legal = state_legal(r_state);
  assign w_resp  = (r_state == ST_RESPOND);
  // An illegal state shows reset values on every output for its one cycle
  assign w_gnt   = w_legal ? r_gnt : '0;

  // Operand mux: OR of the slices selected by the one-hot grant
  always_comb begin
    w_dp_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_dp_in = w_dp_in | i_req_data[i*W +: W];
    end
  end

  // Output decode from state; response fields are zero outside RESPOND
  always_comb begin
    o_gnt       = w_gnt;
    o_dp_in     = w_dp_in;
    o_capture   = cap_strobe(r_state);
    o_op        = (r_state == ST_OPERATE);
    o_valid     = w_resp;
    o_resp_id   = w_resp ? r_gnt_idx : '0;
    o_resp_data = w_resp ? (r_first ? i_dp_result : r_held) : '0;
    o_busy      = w_legal && (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_dp_scheduler.sv
// Self-checking bench for dp_scheduler. A transaction-level model predicts
// the round-robin owner and the full per-cycle output timeline; a small
// datapath model in the bench consumes the capture/op strobes and returns
// A + (B ^ C) + D, with noise on dp_result whenever no result is valid.
module tb_dp_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = $clog2(N);
  localparam int OW = N + 4 + 3 + IW + W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [3:0]     capture;
  logic           op;
  logic [W-1:0]   dp_in;
  logic [W-1:0]   dp_result;
  logic           valid;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_ready = 1'b0;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int m_last = N - 1;

  always #5 clk = ~clk;

  dp_scheduler #(.N_REQ(N), .W(W)) dut (
    .i_clock      (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_req_data   (req_data),
    .o_gnt        (gnt),
    .o_capture    (capture),
    .o_op         (op),
    .o_dp_in      (dp_in),
    .i_dp_result  (dp_result),
    .o_valid      (valid),
    .o_resp_id    (resp_id),
    .o_resp_data  (resp_data),
    .i_resp_ready (resp_ready),
    .o_busy       (busy)
  );

  // Behavioural shared datapath
  logic [W-1:0] da = '0, db = '0, dc = '0, dd = '0, dres = '0, dgarb = '0;
  logic         dres_v = 1'b0;
  always @(posedge clk) begin
    if (capture[0]) da <= dp_in;
    if (capture[1]) db <= dp_in;
    if (capture[2]) dc <= dp_in;
    if (capture[3]) dd <= dp_in;
    if (op) dres <= da + (db ^ dc) + dd;
    dres_v <= op;
    dgarb  <= W'($urandom);
  end
  assign dp_result = dres_v ? dres : dgarb;

  wire [OW-1:0] obs = {gnt, capture, op, valid, busy, resp_id, resp_data};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester at or after last+1, wrapping
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; req = '0; resp_ready = 1'b0;
    step; step;
    rst_n = 1'b1;
    m_last = N - 1;
  endtask

  // Entered in the expected CAP_A cycle. Drives the owner's operands, the
  // response handshake and the next request level, and checks every cycle
  // against the expected timeline (plus the IDLE cycle when nxt is empty).
  task automatic run_txn(input string tag, input int owner, input int stall,
                         input logic [N-1:0] drop, input logic [N-1:0] nxt,
                         input logic [4*W-1:0] ops);
    logic [W-1:0]  o [4];
    logic [W-1:0]  res;
    logic [N-1:0]  e_gnt;
    logic [3:0]    e_cap;
    logic          e_val;
    logic [OW-1:0] exp_v;
    for (int k = 0; k < 4; k++) o[k] = ops[k*W +: W];
    res = o[0] + (o[1] ^ o[2]) + o[3];
    e_gnt = '0;
    e_gnt[owner] = 1'b1;
    for (int c = 0; c < 6 + stall; c++) begin
      e_cap = (c < 4) ? (4'b0001 << c) : 4'b0000;
      e_val = (c >= 5);
      exp_v = {e_gnt, e_cap, (c == 4), e_val, 1'b1,
               e_val ? IW'(owner) : IW'(0), e_val ? res : W'(0)};
      for (int i = 0; i < N; i++) begin
        req_data[i*W +: W] = W'($urandom);
        if (c < 4 && i == owner) req_data[i*W +: W] = o[c];
      end
      if (c == 1) req = req & ~drop;
      if (c == 5 + stall) begin
        resp_ready = 1'b1;
        req = nxt;
      end else begin
        resp_ready = (c < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h want %h", tag, c, obs, exp_v);
      end
      step;
    end
    resp_ready = 1'b0;
    m_last = owner;
    if (nxt == '0) begin
      n_vec++;
      if (obs !== OW'(0) || dp_in !== W'(0)) begin
        n_err++;
        $display("FAIL %s idle: got %h/%h want 0", tag, obs, dp_in);
      end
    end
  endtask

  task automatic test_reset;
    req = '1; resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      n_vec++;
      if (obs !== OW'(0) || dp_in !== W'(0)) begin
        n_err++;
        $display("FAIL reset cycle %0d: got %h want 0", c, obs);
      end
    end
    req = '0; resp_ready = 1'b0;
    rst_n = 1'b1;
    m_last = N - 1;
    step;
    n_vec++;
    if (obs !== OW'(0)) begin
      n_err++;
      $display("FAIL reset_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_single;
    req = 4'b0001;
    step;
    run_txn("single", 0, 0, '0, '0, {8'h44, 8'h33, 8'h22, 8'h11});
  endtask

  task automatic test_backpressure;
    req = 4'b0010;
    step;
    run_txn("backpressure", 1, 3, '0, '0, 32'($urandom));
  endtask

  task automatic test_drop;
    req = 4'b0100;
    step;
    run_txn("drop", 2, 0, 4'b0100, '0, 32'($urandom));
  endtask

  task automatic test_contention;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset;
    req = 4'b1111;
    step;
    for (int t = 0; t < 5; t++)
      run_txn("contention", order[t], 0, '0, (t == 4) ? 4'b0000 : 4'b1111, 32'($urandom));
  endtask

  task automatic test_reset_operate;
    do_reset;
    req = 4'b1000;
    step;
    for (int c = 0; c < 4; c++) step;
    n_vec++;
    if ({op, busy, gnt} !== {2'b11, 4'b1000}) begin
      n_err++;
      $display("FAIL rst_op_pre: got %b%b%b want 111000", op, busy, gnt);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== OW'(0) || dp_in !== W'(0)) begin
      n_err++;
      $display("FAIL rst_op_async: got %h want 0", obs);
    end
    step; step;
    n_vec++;
    if (obs !== OW'(0)) begin
      n_err++;
      $display("FAIL rst_op_hold: got %h want 0", obs);
    end
    rst_n = 1'b1;
    m_last = N - 1;
    req = 4'b0110;
    step;
    run_txn("rst_op_after", 1, 0, '0, '0, 32'($urandom));
  endtask

  task automatic test_fairness;
    logic [N-1:0] nxt;
    int owner, waits;
    bit pend3;
    do_reset;
    req = 4'b0001;
    owner = rr_pick(req, m_last);
    pend3 = 1'b0;
    waits = 0;
    step;
    for (int t = 0; t < 16; t++) begin
      nxt = 4'b0001;
      if (t % 3 == 1) pend3 = 1'b1;
      if (pend3) nxt[3] = 1'b1;
      if (t == 15) nxt = '0;
      run_txn("fairness", owner, 0, '0, nxt, 32'($urandom));
      if (t < 15) begin
        owner = rr_pick(nxt, m_last);
        if (pend3) begin
          n_vec++;
          if (!gnt[3] && waits >= 1) begin
            n_err++;
            $display("FAIL fairness_bound: req3 waited %0d txns, limit 1", waits + 1);
          end
          if (gnt[3]) begin
            pend3 = 1'b0;
            waits = 0;
          end else begin
            waits++;
          end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [N-1:0] nxt;
    int owner, stall;
    bit idle;
    idle = 1'b1;
    owner = 0;
    for (int t = 0; t < 30; t++) begin
      if (idle) begin
        req = N'($urandom_range(1, (1 << N) - 1));
        owner = rr_pick(req, m_last);
        step;
      end
      stall = $urandom_range(0, 3);
      nxt = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
      run_txn("random", owner, stall, N'($urandom), nxt, 32'($urandom));
      idle = (nxt == '0);
      if (!idle) owner = rr_pick(nxt, m_last);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_drop;
    test_contention;
    test_reset_operate;
    test_fairness;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
